// File: rtl/apb_pkg.sv
// Shared types for the APB command sequencer: FSM states, command bundle,
// default bus widths and a one-hot helper used to vet slave selects.
package apb_pkg;

    localparam int SEL_W  = 3;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic              write;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } apb_cmd_t;

    // True when exactly one bit is set; zero is not one-hot.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/apb_cmd_sequencer_if.sv
// APB requester-side bus bundle between the sequencer and the arbiter.
// master: drives PSEL/PENABLE/PADDR/PWRITE/PWDATA, samples PREADY/PRDATA/PSLVERR.
interface apb_cmd_sequencer_if #(
    parameter int SEL_WIDTH  = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [SEL_WIDTH-1:0]  o_PSEL;
    logic                  o_PENABLE;
    logic [ADDR_WIDTH-1:0] o_PADDR;
    logic                  o_PWRITE;
    logic [DATA_WIDTH-1:0] o_PWDATA;
    logic                  i_PREADY;
    logic [DATA_WIDTH-1:0] i_PRDATA;
    logic                  i_PSLVERR;

    modport master (
        output o_PSEL, o_PENABLE, o_PADDR, o_PWRITE, o_PWDATA,
        input  i_PREADY, i_PRDATA, i_PSLVERR
    );

    modport slave (
        input  o_PSEL, o_PENABLE, o_PADDR, o_PWRITE, o_PWDATA,
        output i_PREADY, i_PRDATA, i_PSLVERR
    );
endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers.
// Ports: push/din write, pop advances head, full/empty flags, head = oldest entry.
module apb_cmd_fifo
    import apb_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = apb_cmd_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     din,
    output logic full,
    output logic empty,
    output T     head
);
    localparam int AW = $clog2(DEPTH);

    T             mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end

    // Same slot, opposite lap bit => full.
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty = (wp == rp);
    assign head  = mem[rp[AW-1:0]];
endmodule

// File: rtl/apb_cmd_sequencer.sv
// Queues commands and runs one APB SETUP/ACCESS transfer per command.
// Ports: cmd valid/ready in, rsp valid/ready out, APB master via apb bundle.
module apb_cmd_sequencer
    import apb_pkg::*;
#(
    parameter int SEL_WIDTH      = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  i_PCLK,
    input  logic                  i_PRESET,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [SEL_WIDTH-1:0]  i_cmd_sel,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_error,
    apb_cmd_sequencer_if.master   apb
);
    typedef struct packed {
        logic                  write;
        logic [SEL_WIDTH-1:0]  sel;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    apb_state_e            state_q, state_d;
    cmd_t                  cmd_in, head, cmd_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  rdy_en_q;
    logic                  full, empty, push, pop, load;

    assign cmd_in      = '{i_cmd_write, i_cmd_sel, i_cmd_addr, i_cmd_wdata};
    // Held low through reset, released on the first edge afterwards.
    assign o_cmd_ready = rdy_en_q && !full;
    assign push        = i_cmd_valid && o_cmd_ready;

    apb_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .T     (cmd_t)
    ) u_fifo (
        .clk   (i_PCLK),
        .rst   (i_PRESET),
        .push  (push),
        .pop   (pop),
        .din   (cmd_in),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge i_PCLK or posedge i_PRESET) begin
        if (i_PRESET) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rdy_en_q <= 1'b1;
            if (load) cmd_q <= head;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        pop     = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop   = 1'b1;
                    cnt_d = '0;
                    if (is_onehot(32'(head.sel))) begin
                        load    = 1'b1;
                        state_d = SETUP;
                    end else begin
                        // Bad select never reaches the bus.
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // PREADY is checked first so it beats a same-edge timeout.
                if (apb.i_PREADY) begin
                    err_d   = apb.i_PSLVERR;
                    rdata_d = (!cmd_q.write && !apb.i_PSLVERR) ?
                              apb.i_PRDATA : '0;
                    state_d = RESP;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: if (i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // PSEL/PENABLE decode straight from state so reset drops them at once.
    assign apb.o_PSEL    = (state_q == SETUP || state_q == ACCESS) ?
                           cmd_q.sel : '0;
    assign apb.o_PENABLE = (state_q == ACCESS);
    assign apb.o_PADDR   = cmd_q.addr;
    assign apb.o_PWRITE  = cmd_q.write;
    assign apb.o_PWDATA  = cmd_q.wdata;

    assign o_rsp_valid = (state_q == RESP);
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_error = err_q;
endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Self-checking bench for apb_cmd_sequencer with a transaction-level
// reference model and a reactive APB slave.
module tb_apb_cmd_sequencer;

    localparam int TMO = 16;

    typedef struct {
        bit          write;
        logic [2:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wt;
        logic [31:0] prdata;
        bit          perr;
    } tcmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [2:0]  cmd_sel = '0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    apb_cmd_sequencer_if #(.SEL_WIDTH(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_cmd_sequencer #(
        .SEL_WIDTH      (3),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .CMD_DEPTH      (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_PCLK      (clk),
        .i_PRESET    (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_write (cmd_write),
        .i_cmd_sel   (cmd_sel),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_wdata (cmd_wdata),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_error (rsp_error),
        .apb         (bus)
    );

    always #5 clk = ~clk;

    tcmd_t send_q[$];
    tcmd_t pend_q[$];
    int    take_cyc[$];
    int    acc_cnt = 0;
    int    cyc = 0;
    bit    send_en = 1'b1;
    int    n_run = 0;
    int    n_fail = 0;

    function automatic tcmd_t mk(bit w, logic [2:0] s, logic [31:0] a,
                                 logic [31:0] d, int wt,
                                 logic [31:0] prd, bit pe);
        tcmd_t c;
        c.write = w; c.sel = s; c.addr = a; c.wdata = d;
        c.wt = wt; c.prdata = prd; c.perr = pe;
        return c;
    endfunction

    // Expected response and ACCESS-cycle count from the command's rules.
    task automatic expect_of(input tcmd_t c, output bit err,
                             output logic [31:0] rd, output int acc);
        if ($countones(c.sel) != 1) begin
            err = 1'b1; rd = '0; acc = 0;
        end else if (c.wt >= TMO) begin
            err = 1'b1; rd = '0; acc = TMO;
        end else begin
            err = c.perr;
            rd  = (!c.write && !c.perr) ? c.prdata : 32'h0;
            acc = c.wt + 1;
        end
    endtask

    task automatic drive_cmd();
        if (send_en && send_q.size() > 0) begin
            cmd_valid = 1'b1;
            cmd_write = send_q[0].write;
            cmd_sel   = send_q[0].sel;
            cmd_addr  = send_q[0].addr;
            cmd_wdata = send_q[0].wdata;
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    // Slave answers in ACCESS once the configured wait count has elapsed.
    task automatic slave_drive();
        bit rdy;
        if (bus.o_PENABLE === 1'b1 && pend_q.size() > 0) begin
            rdy = (acc_cnt == pend_q[0].wt);
            bus.i_PREADY  = rdy;
            bus.i_PRDATA  = rdy ? pend_q[0].prdata : $urandom;
            bus.i_PSLVERR = rdy ? pend_q[0].perr : 1'($urandom);
        end else begin
            bus.i_PREADY  = 1'($urandom);
            bus.i_PRDATA  = $urandom;
            bus.i_PSLVERR = 1'($urandom);
        end
    endtask

    task automatic cycle();
        bit          push, take, e_err;
        logic [31:0] e_rd;
        int          e_acc;
        tcmd_t       c;
        drive_cmd();
        push = cmd_valid && cmd_ready;
        take = rsp_valid && rsp_ready;
        if (bus.o_PSEL !== 3'b000) begin
            n_run++;
            if (pend_q.size() == 0 || rsp_valid !== 1'b0 ||
                $countones(bus.o_PSEL) != 1) begin
                n_fail++;
                $display("FAIL apb_unexpected psel=%b rsp_valid=%b",
                         bus.o_PSEL, rsp_valid);
            end else begin
                c = pend_q[0];
                if (bus.o_PSEL !== c.sel || bus.o_PADDR !== c.addr ||
                    bus.o_PWRITE !== c.write ||
                    (c.write && bus.o_PWDATA !== c.wdata)) begin
                    n_fail++;
                    $display("FAIL apb_fields got sel=%b a=%h w=%b d=%h exp sel=%b a=%h w=%b d=%h",
                             bus.o_PSEL, bus.o_PADDR, bus.o_PWRITE, bus.o_PWDATA,
                             c.sel, c.addr, c.write, c.wdata);
                end
            end
        end
        if (bus.o_PENABLE === 1'b1) acc_cnt++;
        if (take) begin
            if (pend_q.size() == 0) begin
                n_run++; n_fail++;
                $display("FAIL rsp_unexpected err=%b rdata=%h", rsp_error, rsp_rdata);
            end else begin
                expect_of(pend_q[0], e_err, e_rd, e_acc);
                n_run++;
                if (rsp_error !== e_err || rsp_rdata !== e_rd) begin
                    n_fail++;
                    $display("FAIL rsp got err=%b rdata=%h exp err=%b rdata=%h",
                             rsp_error, rsp_rdata, e_err, e_rd);
                end
                n_run++;
                if (acc_cnt != e_acc) begin
                    n_fail++;
                    $display("FAIL access_cycles got %0d exp %0d", acc_cnt, e_acc);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (take) begin
            if (pend_q.size() > 0) void'(pend_q.pop_front());
            acc_cnt = 0;
            take_cyc.push_back(cyc);
        end
        if (push) begin
            pend_q.push_back(send_q[0]);
            void'(send_q.pop_front());
        end
        slave_drive();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((send_q.size() > 0 || pend_q.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        n_run++;
        if (send_q.size() > 0 || pend_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain_timeout left send=%0d pend=%0d exp 0",
                     send_q.size(), pend_q.size());
            send_q.delete();
            pend_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        n_run++;
        if (bus.o_PSEL !== 3'b0 || bus.o_PENABLE !== 1'b0 || bus.o_PADDR !== 32'h0 ||
            bus.o_PWRITE !== 1'b0 || bus.o_PWDATA !== 32'h0 || rsp_valid !== 1'b0 ||
            rsp_rdata !== 32'h0 || rsp_error !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs psel=%b pen=%b rv=%b rdy=%b exp all 0",
                     bus.o_PSEL, bus.o_PENABLE, rsp_valid, cmd_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_run++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge got %b exp 0", cmd_ready);
        end
        @(posedge clk);
        #1;
        n_run++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_edge got %b exp 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        rsp_ready = 1'b1;
        send_q.push_back(mk(1, 3'b001, 32'h4, 32'h12345678, 0, 32'h0, 0));
        cycle();
        n_run++;
        if (bus.o_PSEL !== 3'b000 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_idle psel=%b rv=%b exp 000/0", bus.o_PSEL, rsp_valid);
        end
        cycle();
        n_run++;
        if (bus.o_PSEL !== 3'b001 || bus.o_PENABLE !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_setup psel=%b pen=%b exp 001/0", bus.o_PSEL, bus.o_PENABLE);
        end
        cycle();
        n_run++;
        if (bus.o_PSEL !== 3'b001 || bus.o_PENABLE !== 1'b1 ||
            bus.o_PWDATA !== 32'h12345678) begin
            n_fail++;
            $display("FAIL lat_access psel=%b pen=%b d=%h exp 001/1/12345678",
                     bus.o_PSEL, bus.o_PENABLE, bus.o_PWDATA);
        end
        cycle();
        n_run++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0 ||
            bus.o_PSEL !== 3'b000 || bus.o_PENABLE !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_resp rv=%b err=%b rd=%h psel=%b exp 1/0/0/000",
                     rsp_valid, rsp_error, rsp_rdata, bus.o_PSEL);
        end
        cycle();
        n_run++;
        if (rsp_valid !== 1'b0 || bus.o_PADDR !== 32'h4) begin
            n_fail++;
            $display("FAIL after_resp rv=%b paddr=%h exp 0/4", rsp_valid, bus.o_PADDR);
        end
    endtask

    task automatic test_read_wait();
        rsp_ready = 1'b1;
        send_q.push_back(mk(0, 3'b010, 32'h8, 32'h0, 2, 32'hDEADBEEF, 0));
        drain(50);
    endtask

    task automatic test_fifo_full();
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            send_q.push_back(mk(i[0], 3'b001 << (i % 3), 32'h100 + i * 4,
                                $urandom, 0, $urandom, 0));
        repeat (10) cycle();
        n_run++;
        if (pend_q.size() != 5 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fifo_full accepted=%0d rdy=%b exp 5/0", pend_q.size(), cmd_ready);
        end
        take_cyc.delete();
        rsp_ready = 1'b1;
        drain(100);
        n_run++;
        if (take_cyc.size() != 6) begin
            n_fail++;
            $display("FAIL fifo_rsp_count got %0d exp 6", take_cyc.size());
        end
        for (int i = 1; i < take_cyc.size(); i++) begin
            n_run++;
            if (take_cyc[i] - take_cyc[i-1] != 4) begin
                n_fail++;
                $display("FAIL throughput gap %0d got %0d exp 4", i,
                         take_cyc[i] - take_cyc[i-1]);
            end
        end
    endtask

    task automatic test_timeout();
        rsp_ready = 1'b1;
        send_q.push_back(mk(1, 3'b001, 32'h20, 32'hA5A5A5A5, 1000, 32'h0, 0));
        send_q.push_back(mk(0, 3'b100, 32'h24, 32'h0, 15, 32'h13572468, 0));
        send_q.push_back(mk(0, 3'b010, 32'h28, 32'h0, 1, 32'hCAFEF00D, 0));
        drain(200);
    endtask

    task automatic test_errors();
        rsp_ready = 1'b1;
        send_q.push_back(mk(1, 3'b011, 32'h30, 32'h1, 0, 32'h0, 0));
        send_q.push_back(mk(0, 3'b000, 32'h34, 32'h0, 0, 32'h0, 0));
        send_q.push_back(mk(0, 3'b100, 32'h38, 32'h0, 0, 32'hFFFF0000, 1));
        drain(100);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            send_q.push_back(mk(0, 3'b010, 32'h40 + i, 32'h0, 6, $urandom, 0));
        while (bus.o_PENABLE !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        cycle();
        cycle();
        #2 rst = 1'b1;
        #1;
        n_run++;
        if (bus.o_PSEL !== 3'b0 || bus.o_PENABLE !== 1'b0 ||
            rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset psel=%b pen=%b rv=%b rdy=%b exp 0",
                     bus.o_PSEL, bus.o_PENABLE, rsp_valid, cmd_ready);
        end
        send_q.delete();
        pend_q.delete();
        acc_cnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) cycle();
        n_run++;
        if (bus.o_PSEL !== 3'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset psel=%b rv=%b rdy=%b exp 000/0/1",
                     bus.o_PSEL, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_random();
        tcmd_t c;
        int    r;
        int    n = 0;
        for (int i = 0; i < 60; i++) begin
            c.write  = 1'($urandom);
            c.sel    = ($urandom_range(0, 9) < 8) ?
                       3'(1 << $urandom_range(0, 2)) : 3'($urandom);
            c.addr   = $urandom;
            c.wdata  = $urandom;
            c.prdata = $urandom;
            c.perr   = ($urandom_range(0, 5) == 0);
            r = $urandom_range(0, 9);
            c.wt = (r < 7) ? $urandom_range(0, 3) : (r == 7) ? 15 :
                   (r == 8) ? TMO : $urandom_range(4, 14);
            send_q.push_back(c);
        end
        while ((send_q.size() > 0 || pend_q.size() > 0) && n < 5000) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            send_en   = ($urandom_range(0, 2) != 0);
            cycle();
            n++;
        end
        send_en   = 1'b1;
        rsp_ready = 1'b1;
        drain(500);
    endtask

    initial begin
        bus.i_PREADY  = 1'b0;
        bus.i_PRDATA  = '0;
        bus.i_PSLVERR = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_fifo_full();
        test_timeout();
        test_errors();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
